// File: rtl/sfu_ctrl.sv
// sfu_ctrl: feeds acc_len psum vectors per output into a row of SFU lanes, then writes packed ReLU results.
// Optional DRAIN timeout with sticky err output: define SFU_CTRL_TIMEOUT_EN.

module sfu_ctrl_lane #(
  parameter int psum_bw = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic               valid_out,
  input  logic [psum_bw-1:0] psum_out,
  output logic               flag,
  output logic [psum_bw-1:0] cap
);
  // Only the first valid result per output is kept; later pulses or a held valid are ignored.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      flag <= 1'b0;
      cap  <= '0;
    end else if (en && valid_out && !flag) begin
      flag <= 1'b1;
      cap  <= psum_out;
    end
  end
endmodule

module sfu_ctrl #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int len_bw  = 8,
  parameter int addr_bw = 10
`ifdef SFU_CTRL_TIMEOUT_EN
  ,
  parameter int drain_max = 64
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [len_bw-1:0]        acc_len,
  input  logic [len_bw-1:0]        num_out,
  input  logic [addr_bw-1:0]       mem_base,
  input  logic                     ofifo_valid,
  input  logic [col*psum_bw-1:0]   ofifo_dout,
  output logic                     ofifo_rd,
  output logic                     sfu_rstn,
  output logic                     sfu_valid_in,
  output logic [col*psum_bw-1:0]   sfu_psum_in,
  input  logic [col-1:0]           sfu_valid_out,
  input  logic [col*psum_bw-1:0]   sfu_psum_out,
  output logic                     mem_wr,
  output logic [addr_bw-1:0]       mem_addr,
  output logic [col*psum_bw-1:0]   mem_din,
  output logic                     busy,
  output logic                     done
`ifdef SFU_CTRL_TIMEOUT_EN
  ,
  output logic                     err
`endif
);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, WRITE, DONE} state_t;
  state_t state, state_nxt;

  logic [len_bw-1:0]            acc_len_q, num_out_q, feed_cnt, out_cnt;
  logic [addr_bw-1:0]           addr;
  logic [col-1:0]               lane_flag;
  logic [col-1:0][psum_bw-1:0]  lane_cap, lane_res;
  logic                         lane_clr, lane_en, all_cap, drain_to, job_ok;

  assign lane_res = sfu_psum_out;
  assign lane_clr = (state == CLEAR);
  assign lane_en  = (state == DRAIN);
  assign all_cap  = &lane_flag;
  assign job_ok   = (acc_len != '0) && (num_out != '0);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  generate
    for (genvar i = 0; i < col; i++) begin : g_lane
      sfu_ctrl_lane #(.psum_bw(psum_bw)) u_lane (
        .clk       (clk),
        .rst       (rst),
        .clr       (lane_clr),
        .en        (lane_en),
        .valid_out (sfu_valid_out[i]),
        .psum_out  (lane_res[i]),
        .flag      (lane_flag[i]),
        .cap       (lane_cap[i])
      );
    end
  endgenerate

`ifdef SFU_CTRL_TIMEOUT_EN
  localparam int dw = $clog2(drain_max + 1);
  logic [dw-1:0] drain_cnt;

  // Give up after drain_max DRAIN cycles; uncaptured lanes keep their cleared value of 0.
  assign drain_to = (state == DRAIN) && !all_cap && (drain_cnt == dw'(drain_max - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt <= '0;
      err       <= 1'b0;
    end else begin
      if (state == IDLE && start) err <= 1'b0;
      if (drain_to) err <= 1'b1;
      if (state == CLEAR)      drain_cnt <= '0;
      else if (state == DRAIN) drain_cnt <= drain_cnt + dw'(1);
    end
  end
`else
  assign drain_to = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ofifo_rd  = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = job_ok ? CLEAR : DONE;
      CLEAR: state_nxt = FEED;
      FEED: begin
        if (ofifo_valid && (feed_cnt < acc_len_q)) begin
          ofifo_rd = 1'b1;
          if (feed_cnt + len_bw'(1) == acc_len_q) state_nxt = DRAIN;
        end
      end
      DRAIN: if (all_cap || drain_to) state_nxt = WRITE;
      WRITE: state_nxt = (out_cnt + len_bw'(1) == num_out_q) ? DONE : CLEAR;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sfu_rstn     <= 1'b0;
      sfu_valid_in <= 1'b0;
      sfu_psum_in  <= '0;
      mem_wr       <= 1'b0;
      mem_addr     <= '0;
      mem_din      <= '0;
      acc_len_q    <= '0;
      num_out_q    <= '0;
      feed_cnt     <= '0;
      out_cnt      <= '0;
      addr         <= '0;
    end else begin
      // Clear pulse lands in the first FEED cycle, where valid_in is still low.
      sfu_rstn     <= (state != CLEAR);
      sfu_valid_in <= ofifo_rd;
      mem_wr       <= 1'b0;
      if (ofifo_rd) begin
        sfu_psum_in <= ofifo_dout;
        feed_cnt    <= feed_cnt + len_bw'(1);
      end
      case (state)
        IDLE: if (start) begin
          acc_len_q <= acc_len;
          num_out_q <= num_out;
          addr      <= mem_base;
          out_cnt   <= '0;
        end
        CLEAR: feed_cnt <= '0;
        DRAIN: if (all_cap || drain_to) begin
          mem_wr   <= 1'b1;
          mem_addr <= addr;
          mem_din  <= lane_cap;
        end
        WRITE: begin
          addr    <= addr + addr_bw'(1);
          out_cnt <= out_cnt + len_bw'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sfu_ctrl.sv
// Directed bench for sfu_ctrl with a FWFT FIFO model and a behavioural accumulate+ReLU lane model.
// Define SFU_CTRL_TIMEOUT_EN to also exercise the DRAIN timeout.

module tb_sfu_ctrl;
  localparam int col = 8, psum_bw = 16, len_bw = 8, addr_bw = 10;
  localparam int W = col * psum_bw;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stall = 1'b0;
  logic [len_bw-1:0]  acc_len = '0, num_out = '0;
  logic [addr_bw-1:0] mem_base = '0;
  logic ofifo_valid, ofifo_rd, sfu_rstn, sfu_valid_in, mem_wr, busy, done;
  logic [W-1:0] ofifo_dout, sfu_psum_in, sfu_psum_out, mem_din;
  logic [col-1:0] sfu_valid_out;
  logic [col-1:0] lane_dead = '0;
  logic [addr_bw-1:0] mem_addr;
`ifdef SFU_CTRL_TIMEOUT_EN
  logic err;
`endif

  sfu_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .acc_len(acc_len), .num_out(num_out),
    .mem_base(mem_base), .ofifo_valid(ofifo_valid), .ofifo_dout(ofifo_dout),
    .ofifo_rd(ofifo_rd), .sfu_rstn(sfu_rstn), .sfu_valid_in(sfu_valid_in),
    .sfu_psum_in(sfu_psum_in), .sfu_valid_out(sfu_valid_out), .sfu_psum_out(sfu_psum_out),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din), .busy(busy), .done(done)
`ifdef SFU_CTRL_TIMEOUT_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  // FWFT FIFO model
  logic [W-1:0] fifo_mem [256];
  int wr_ptr = 0, rd_ptr = 0;
  assign ofifo_valid = (rd_ptr != wr_ptr) && !stall;
  assign ofifo_dout  = fifo_mem[rd_ptr];
  always @(posedge clk) if (ofifo_rd) rd_ptr <= rd_ptr + 1;

  // Lane model: accumulate on valid_in, result valid one cycle after the valid_in burst ends
  logic signed [psum_bw-1:0] acc [col];
  logic vin_q = 1'b0;
  always @(posedge clk) begin
    vin_q <= sfu_valid_in;
    for (int i = 0; i < col; i++)
      if (!sfu_rstn) acc[i] <= '0;
      else if (sfu_valid_in) acc[i] <= acc[i] + $signed(sfu_psum_in[i*psum_bw +: psum_bw]);
  end
  generate
    for (genvar i = 0; i < col; i++) begin : g_sfu
      assign sfu_valid_out[i] = vin_q & ~sfu_valid_in & ~lane_dead[i];
      assign sfu_psum_out[i*psum_bw +: psum_bw] = acc[i][psum_bw-1] ? '0 : acc[i];
    end
  endgenerate

  // Event monitor
  int n_rd = 0, n_vin = 0, n_rlo = 0, n_done = 0, n_wr = 0, n_viol = 0;
  logic [addr_bw-1:0] wr_addr [16];
  logic [W-1:0]       wr_data [16];
  always @(negedge clk) begin
    if (ofifo_rd)     n_rd  <= n_rd + 1;
    if (sfu_valid_in) n_vin <= n_vin + 1;
    if (!sfu_rstn)    n_rlo <= n_rlo + 1;
    if (done)         n_done <= n_done + 1;
    if ((sfu_valid_in && !sfu_rstn) || (ofifo_rd && !ofifo_valid)) n_viol <= n_viol + 1;
    if (mem_wr) begin
      wr_addr[n_wr % 16] <= mem_addr;
      wr_data[n_wr % 16] <= mem_din;
      n_wr <= n_wr + 1;
    end
  end

  int n_chk = 0, n_err = 0;
  int s_rd, s_vin, s_rlo, s_done, s_wr, cyc;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_rd = n_rd; s_vin = n_vin; s_rlo = n_rlo; s_done = n_done; s_wr = n_wr;
  endtask

  task automatic push_lanes(input int a, input int step);
    logic [W-1:0] v;
    for (int i = 0; i < col; i++) v[i*psum_bw +: psum_bw] = psum_bw'(a + i * step);
    fifo_mem[wr_ptr] = v;
    wr_ptr++;
  endtask

  function automatic logic [255:0] exp_vec(input int a, input int step);
    logic [255:0] r;
    int v;
    r = '0;
    for (int i = 0; i < col; i++) begin
      v = a + i * step;
      if (v > 0) r[i*psum_bw +: psum_bw] = psum_bw'(v);
    end
    return r;
  endfunction

  task automatic job(input int al, input int no, input int base);
    acc_len = len_bw'(al); num_out = len_bw'(no); mem_base = addr_bw'(base);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int c);
    c = 0;
    while (done !== 1'b1 && c < budget) begin @(negedge clk); c++; end
    chk({tag, "_done"}, 256'(done), 256'(1));
  endtask

  task automatic wait_rd(input string tag, input int budget);
    int k = 0;
    while (ofifo_rd !== 1'b1 && k < budget) begin @(negedge clk); k++; end
    chk({tag, "_rd"}, 256'(ofifo_rd), 256'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [255:0] e;
    idle(2);
    chk("rst_busy_done", {254'd0, busy, done}, 256'(0));
    chk("rst_sfu", {253'd0, sfu_rstn, sfu_valid_in, ofifo_rd}, 256'(0));
    chk("rst_mem", {125'd0, mem_wr, mem_addr, mem_din}, 256'(0));
    chk("rst_psum_in", 256'(sfu_psum_in), 256'(0));
`ifdef SFU_CTRL_TIMEOUT_EN
    chk("rst_err", 256'(err), 256'(0));
`endif
    rst = 1'b0;
    idle(3);
    chk("post_rst_rstn", 256'(sfu_rstn), 256'(1));

    // 1: acc_len=5, single output, 1..5 on every lane
    for (int v = 1; v <= 5; v++) push_lanes(v, 0);
    snap();
    job(5, 1, 'h010);
    chk("t1_busy", 256'(busy), 256'(1));
    wait_done("t1", 200, cyc);
    chk("t1_latency", 256'(cyc), 256'(10));
    idle(1);
    chk("t1_idle", {254'd0, busy, done}, 256'(0));
    chk("t1_nvin", 256'(n_vin - s_vin), 256'(5));
    chk("t1_nwr", 256'(n_wr - s_wr), 256'(1));
    chk("t1_addr", 256'(wr_addr[s_wr % 16]), 256'('h010));
    chk("t1_data", 256'(wr_data[s_wr % 16]), exp_vec(15, 0));

    // 2: -3 then +1 clamps to 0
    push_lanes(-3, 0); push_lanes(1, 0);
    snap();
    job(2, 1, 'h020);
    wait_done("t2", 200, cyc);
    idle(2);
    chk("t2_addr", 256'(wr_addr[s_wr % 16]), 256'('h020));
    chk("t2_data", 256'(wr_data[s_wr % 16]), exp_vec(-2, 0));

    // 3: three outputs, 3-cycle FIFO stall inside the first feed
    push_lanes(1, 1);
    snap();
    job(2, 3, 'h100);
    wait_rd("t3", 20);
    @(posedge clk); #1 stall = 1'b1;
    push_lanes(10, 0); push_lanes(2, 2); push_lanes(0, 1); push_lanes(5, -1); push_lanes(0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_stall_rd", 256'(ofifo_rd), 256'(0));
      if (k > 0) chk("t3_stall_vin", 256'(sfu_valid_in), 256'(0));
    end
    @(posedge clk); #1 stall = 1'b0;
    wait_done("t3", 300, cyc);
    idle(2);
    chk("t3_nwr", 256'(n_wr - s_wr), 256'(3));
    chk("t3_nrd", 256'(n_rd - s_rd), 256'(6));
    chk("t3_rstn_lo", 256'(n_rlo - s_rlo), 256'(3));
    chk("t3_addr0", 256'(wr_addr[s_wr % 16]), 256'('h100));
    chk("t3_addr1", 256'(wr_addr[(s_wr + 1) % 16]), 256'('h101));
    chk("t3_addr2", 256'(wr_addr[(s_wr + 2) % 16]), 256'('h102));
    chk("t3_data0", 256'(wr_data[s_wr % 16]), exp_vec(11, 1));
    chk("t3_data1", 256'(wr_data[(s_wr + 1) % 16]), exp_vec(2, 3));
    chk("t3_data2", 256'(wr_data[(s_wr + 2) % 16]), exp_vec(5, -1));

    // 4: empty job, then a start while busy is ignored
    snap();
    job(3, 0, 'h0aa);
    wait_done("t4a", 2, cyc);
    idle(2);
    chk("t4a_quiet", 256'((n_rd - s_rd) + (n_wr - s_wr) + (n_vin - s_vin)), 256'(0));
    chk("t4a_ndone", 256'(n_done - s_done), 256'(1));
    snap();
    job(1, 1, 'h200);
    idle(2);
    job(2, 2, 'h300);
    chk("t4b_busy", 256'(busy), 256'(1));
    push_lanes(7, 0);
    wait_done("t4b", 200, cyc);
    idle(3);
    chk("t4b_ndone", 256'(n_done - s_done), 256'(1));
    chk("t4b_nwr", 256'(n_wr - s_wr), 256'(1));
    chk("t4b_addr", 256'(wr_addr[s_wr % 16]), 256'('h200));
    chk("t4b_data", 256'(wr_data[s_wr % 16]), exp_vec(7, 0));

    // 5: reset in FEED aborts; then recovery and address wrap
    push_lanes(1, 0);
    snap();
    job(3, 1, 'h050);
    wait_rd("t5", 20);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_ctl", {251'd0, busy, done, ofifo_rd, sfu_valid_in, mem_wr}, 256'(0));
    chk("t5_rst_rstn", 256'(sfu_rstn), 256'(0));
    chk("t5_rst_psum", 256'(sfu_psum_in), 256'(0));
    rst = 1'b0;
    idle(3);
    chk("t5_abort", 256'((n_done - s_done) + (n_wr - s_wr)), 256'(0));
    push_lanes(3, 2);
    snap();
    job(1, 1, 'h033);
    wait_done("t5b", 200, cyc);
    idle(2);
    chk("t5b_addr", 256'(wr_addr[s_wr % 16]), 256'('h033));
    chk("t5b_data", 256'(wr_data[s_wr % 16]), exp_vec(3, 2));
    push_lanes(4, 0); push_lanes(-1, 0);
    snap();
    job(1, 2, 1023);
    wait_done("t5c", 200, cyc);
    idle(2);
    chk("t5c_addr0", 256'(wr_addr[s_wr % 16]), 256'(1023));
    chk("t5c_addr1", 256'(wr_addr[(s_wr + 1) % 16]), 256'(0));
    chk("t5c_data0", 256'(wr_data[s_wr % 16]), exp_vec(4, 0));
    chk("t5c_data1", 256'(wr_data[(s_wr + 1) % 16]), exp_vec(-1, 0));

`ifdef SFU_CTRL_TIMEOUT_EN
    // 6: lane 3 never reports; timeout after 64 DRAIN cycles
    lane_dead = 8'b0000_1000;
    push_lanes(9, 1);
    snap();
    job(1, 1, 'h3a0);
    wait_done("t6", 200, cyc);
    chk("t6_latency", 256'(cyc), 256'(67));
    chk("t6_err", 256'(err), 256'(1));
    idle(2);
    e = exp_vec(9, 1);
    e[3*psum_bw +: psum_bw] = '0;
    chk("t6_data", 256'(wr_data[s_wr % 16]), e);
    chk("t6_err_sticky", 256'(err), 256'(1));
    lane_dead = '0;
    push_lanes(1, 0);
    job(1, 1, 'h3a1);
    chk("t6_err_clr", 256'(err), 256'(0));
    wait_done("t6b", 200, cyc);
    chk("t6b_err", 256'(err), 256'(0));
    idle(2);
`endif

    chk("protocol_viol", 256'(n_viol), 256'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/sfu_ctrl.md
Name: sfu_ctrl

Overview:
- Sequencer for a row of `col` SFU lanes (accumulate + ReLU, per-lane `valid_in`/`valid_out`) at the array output.
- Pulls partial-sum vectors from the output FIFO and streams `acc_len` vectors per output into the lanes.
- Clears the lane accumulators between outputs, collects the ReLU results and writes one packed word per output to the output SRAM at incrementing addresses.

Parameters:
- col, 8, number of SFU lanes (columns).
- psum_bw, 16, partial-sum width per lane.
- len_bw, 8, width of `acc_len` and `num_out` counters.
- addr_bw, 10, output memory address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a job when idle.
- acc_len  in  len_bw  psum vectors accumulated per output; sampled at start.
- num_out  in  len_bw  outputs in the job; sampled at start.
- mem_base  in  addr_bw  first write address; sampled at start.
- ofifo_valid  in  1  FIFO non-empty; `ofifo_dout` valid (first-word-fall-through).
- ofifo_dout  in  col*psum_bw  psum vector, lane i at bits [i*psum_bw +: psum_bw].
- ofifo_rd  out  1  FIFO pop, combinational.
- sfu_rstn  out  1  active-low accumulator clear to all lanes, registered.
- sfu_valid_in  out  1  registered valid to all lanes.
- sfu_psum_in  out  col*psum_bw  registered psum vector to lanes.
- sfu_valid_out  in  col  per-lane result valid (may pulse or hold).
- sfu_psum_out  in  col*psum_bw  per-lane ReLU result.
- mem_wr  out  1  one-cycle write strobe.
- mem_addr  out  addr_bw  write address.
- mem_din  out  col*psum_bw  packed lane results.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset: state IDLE; `sfu_rstn`=0; `sfu_valid_in`, `sfu_psum_in`, `mem_wr`, `mem_din`, `mem_addr`, `busy`, `done`=0; all counters 0; `ofifo_rd`=0.
- Reset mid-job aborts it: no `done`, no partial write; `sfu_rstn` returns to 1 on the first non-reset cycle.
- States:
  - IDLE: `start` with `acc_len`≠0 and `num_out`≠0 latches `acc_len`, `num_out`, `mem_base` → CLEAR. `start` with either value 0 → DONE (no FIFO/SFU/mem activity).
  - CLEAR (1 cycle): `sfu_rstn`=0 on the following cycle; feed_cnt=0; capture flags cleared → FEED.
  - FEED: `ofifo_rd` = `ofifo_valid` && feed_cnt<acc_len. Each pop registers `sfu_psum_in`<=`ofifo_dout` and `sfu_valid_in`<=1, with 1-cycle latency. No pop → `sfu_valid_in`<=0 and `sfu_psum_in` holds. On the pop making feed_cnt==acc_len → DRAIN.
  - DRAIN: per-lane sticky flag set, and result captured, on the first cycle its `sfu_valid_out` is high. When all col flags are set → WRITE.
  - WRITE (1 cycle): `mem_wr`=1, `mem_din`=captured results, `mem_addr`=current address. Then the address increments, wrapping modulo 2^addr_bw, and out_cnt increments. out_cnt==num_out → DONE, else → CLEAR.
  - DONE (1 cycle): `done`=1, `busy`<=0 → IDLE.
- `start` outside IDLE is ignored.
- `ofifo_rd` is never asserted outside FEED.
- FIFO stalls in FEED are unbounded; no timeout.
- `sfu_valid_in` is never high in the cycle `sfu_rstn` is low.

Optional Feature:
- Macro: SFU_CTRL_TIMEOUT_EN.
- When defined:
  - Adds parameter `drain_max` (default 64) and output `err` (1 bit, reset 0, sticky until rst or next accepted start).
  - A counter runs in DRAIN. Reaching `drain_max` cycles without all flags set → `err`=1; lanes not yet captured write 0 in WRITE, and the sequence continues normally.
- When undefined: no `err` port; DRAIN waits indefinitely.

Test Plan:
1. `acc_len`=5, `num_out`=1, `mem_base`=0x010, FIFO supplies 1,2,3,4,5 on all lanes (behavioural SFU model) → 5 `sfu_valid_in` cycles, one `mem_wr` at 0x010 with every lane 15, `done` pulse, `busy` low afterwards.
2. `acc_len`=2, `num_out`=1, lanes fed -3 then +1 → `mem_din` all lanes 0, written at `mem_base`.
3. `num_out`=3, `acc_len`=2, `ofifo_valid` low for 3 cycles mid-FEED → no `ofifo_rd` and `sfu_valid_in`=0 during the stall; `sfu_rstn` low exactly 1 cycle before each output's feed; writes at base, base+1, base+2.
4. `start` with `num_out`=0 → `done` pulse within 2 cycles, zero `ofifo_rd`/`mem_wr`. Second `start` while busy → ignored, job count unchanged.
5. `rst` asserted during FEED → next cycle all outputs at reset values, no `done`. A subsequent job with `acc_len`=1, `num_out`=1 completes correctly. `mem_base`=1023 with `num_out`=2 → addresses 1023 then 0.
6. (SFU_CTRL_TIMEOUT_EN) lane 3 never asserts `valid_out`, `drain_max`=64 → `err`=1 after 64 DRAIN cycles, lane 3 written 0, other lanes correct, `done` still pulses.
